riscv_lsu_ctrl: RTL and testbench
=================================

Name: riscv_lsu_ctrl

Overview:
- Load/store unit controller that sits directly downstream of the decoder/execute stage.
- Consumes memRead, memWrite and the memAccessType_t access width from the control signals, plus the ALU-computed address and the store data.
- Runs a request/grant/response handshake to the data memory. Generates byte strobes and replicated write data for stores; aligns and sign- or zero-extends load data.
- Stalls the pipeline while a transfer is in flight and flags misaligned, illegal and timed-out accesses.

Parameters:
- DATA_WIDTH, 32, data and address width; the block supports 32 only.
- TIMEOUT_CYCLES, 16, maximum cycles spent in REQ plus WAIT_RESP before the access is aborted with an error.
- CNT_WIDTH, 5, timeout counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  execute stage presents an instruction
- ex_mem_read  in  1  load request (controlSignals_t.memRead)
- ex_mem_write  in  1  store request (controlSignals_t.memWrite)
- ex_access  in  3  memAccessType_t
- ex_addr  in  32  effective byte address
- ex_wdata  in  32  store source register value
- lsu_busy  out  1  stall request to the pipeline
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  valid with lsu_done: misaligned, illegal or timeout
- lsu_rdata  out  32  extended load result, valid with lsu_done
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  memory accepts the request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Reset values: state IDLE, all outputs 0, timeout counter 0.
- Reset mid-operation: the block returns to IDLE immediately and mem_req drops asynchronously. A pending grant or response is discarded.
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE: an access is accepted when ex_valid and exactly one of ex_mem_read or ex_mem_write is set.
  - On acceptance, op, access, addr and wdata are registered.
  - lsu_busy = (state != IDLE) | (ex_valid & (ex_mem_read | ex_mem_write)), combinational. Busy therefore holds the pipeline from the accept cycle until the DONE cycle inclusive.
- Error check at accept; any of these goes to DONE with lsu_err=1 and issues no memory request:
  - ex_mem_read and ex_mem_write both set.
  - ex_access value of 5, 6 or 7.
  - HALF or HALF_U with addr[0]=1.
  - WORD with addr[1:0] != 0.
- REQ:
  - mem_req=1, and mem_we/addr/wstrb/wdata stay stable until mem_gnt.
  - Store with gnt: go to DONE.
  - Load with gnt: go to WAIT_RESP. If mem_rvalid arrives in the same cycle as gnt, capture the data and go straight to DONE.
  - mem_rvalid without gnt in REQ is ignored.
- WAIT_RESP: mem_req=0. On mem_rvalid, capture the aligned, extended data and go to DONE.
- Timeout:
  - The counter clears on accept and increments every cycle spent in REQ or WAIT_RESP.
  - When it reaches TIMEOUT_CYCLES-1 without the exit condition, go to DONE with lsu_err=1 and lsu_rdata=0.
- DONE: lsu_done=1 for exactly one cycle, lsu_busy=1, then IDLE. A new access can be accepted the cycle after DONE.
- Minimum latency, counted from the accept edge:
  - Store with immediate gnt: DONE 2 cycles later.
  - Load with gnt and rvalid one cycle apart: DONE 3 cycles later.
  - Error at accept: DONE 1 cycle later.
- Write strobes: BYTE gives 4'b0001<<addr[1:0]; HALF gives 4'b0011<<addr[1:0]; WORD gives 4'b1111.
- Write data: BYTE gives {4{wdata[7:0]}}; HALF gives {2{wdata[15:0]}}; WORD passes unchanged.
- Load alignment: shifted = mem_rdata >> (8*addr[1:0]).
  - BYTE sign-extends shifted[7:0]; BYTE_U zero-extends it.
  - HALF sign-extends shifted[15:0]; HALF_U zero-extends it.
  - WORD passes the word unchanged.
- mem_wstrb and mem_wdata are driven only while mem_req=1 and mem_we=1; otherwise they are 0.
- lsu_rdata holds its value until the next DONE. It is 0 for stores and errors.

Decomposition:
- riscv_definitions gains these shared items:
  - lsuState_t enum {LSU_IDLE, LSU_REQ, LSU_WAIT_RESP, LSU_DONE}.
  - Constant LSU_TIMEOUT_DEFAULT = 16.
  - Function memStrobe(memAccessType_t, logic[1:0]) returning logic[3:0]; testbench reference models reuse it.
- The existing memAccessType_t and dataBus_t are used unchanged.
- One combinational sub-module, riscv_lsu_load_align, covers the shift and sign/zero extension. The FSM, counter and strobe/write-data generation stay in the top module.

Test Plan:
- SB store: addr=0x1002, wdata=0x000000AB, gnt in the first REQ cycle → mem_addr=0x1000, wstrb=4'b0100, mem_wdata=0xABABABAB; lsu_done 2 cycles after accept with err=0.
- LB versus LBU: addr=0x2003, mem_rdata=0x80FF1234, rvalid 1 cycle after gnt → LB lsu_rdata=0xFFFFFF80; LBU gives 0x00000080; done 3 cycles after accept.
- LH misaligned: addr=0x3001 → no mem_req ever; lsu_done with lsu_err=1 one cycle after accept.
- Ignored response and timeout: LW at 0x4000 with gnt held low for 20 cycles → mem_req high for 16 cycles, then lsu_done with lsu_err=1 and lsu_rdata=0. An mem_rvalid pulse injected in REQ is ignored.
- Reset during WAIT_RESP: assert rst between gnt and rvalid → mem_req, lsu_busy and lsu_done go to 0 asynchronously. A later rvalid causes no lsu_done. A new SW at 0x5000 after reset completes normally with wstrb=4'b1111.
- Back-to-back accesses: SH to 0x6002 followed immediately by LHU from 0x6002 with mem_rdata=0xBEEF0000 → second accept occurs the cycle after the first DONE; SH wstrb=4'b1100; LHU lsu_rdata=0x0000BEEF.

Source files
------------

// File: rtl/riscv_definitions.sv
// Shared RISC-V pipeline types used across stages.
// Adds the LSU controller state and the store byte-strobe helper.
package riscv_definitions;

  typedef logic [31:0] dataBus_t;

  typedef enum logic [2:0] {
    MEM_BYTE   = 3'd0,
    MEM_HALF   = 3'd1,
    MEM_WORD   = 3'd2,
    MEM_BYTE_U = 3'd3,
    MEM_HALF_U = 3'd4
  } memAccessType_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT_RESP,
    LSU_DONE
  } lsuState_t;

  localparam int LSU_TIMEOUT_DEFAULT = 16;

  function automatic logic [3:0] memStrobe(
    input memAccessType_t acc,
    input logic [1:0]     off
  );
    logic [3:0] s;
    s = 4'b0000;
    unique case (1'b1)
      (acc == MEM_BYTE) || (acc == MEM_BYTE_U): s = 4'b0001 << off;
      (acc == MEM_HALF) || (acc == MEM_HALF_U): s = 4'b0011 << off;
      (acc == MEM_WORD):                        s = 4'b1111;
      default:                                  s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/riscv_lsu_load_align.sv
// Load data lane select and sign/zero extension.
// Purely combinational; fed by the registered access and address.
module riscv_lsu_load_align
  import riscv_definitions::*;
(
  input  memAccessType_t access,
  input  logic [1:0]     offset,
  input  dataBus_t       rdata,
  output dataBus_t       data
);

  dataBus_t shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = shifted;
    unique case (1'b1)
      access == MEM_BYTE:   data = {{24{shifted[7]}}, shifted[7:0]};
      access == MEM_BYTE_U: data = {24'h0, shifted[7:0]};
      access == MEM_HALF:   data = {{16{shifted[15]}}, shifted[15:0]};
      access == MEM_HALF_U: data = {16'h0, shifted[15:0]};
      default:              data = shifted;
    endcase
  end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// Load/store unit controller: req/gnt/rvalid handshake to data memory,
// store strobes and lane replication, load alignment, error/timeout flags.
module riscv_lsu_ctrl
  import riscv_definitions::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_access,
  input  logic [DATA_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  output logic                  lsu_busy,
  output logic                  lsu_done,
  output logic                  lsu_err,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  lsuState_t      state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic           we_q, we_d;
  memAccessType_t acc_q, acc_d;
  dataBus_t       addr_q, addr_d;
  dataBus_t       wdata_q, wdata_d;
  logic           err_q, err_d;
  dataBus_t       rdata_q, rdata_d;

  dataBus_t       load_data;
  dataBus_t       wdata_rep;
  logic           req_any;
  logic           accept;
  logic           illegal;
  logic           misalign;
  logic           bad;
  logic           timeout;

  riscv_lsu_load_align u_align (
    .access (acc_q),
    .offset (addr_q[1:0]),
    .rdata  (mem_rdata),
    .data   (load_data)
  );

  assign req_any  = ex_mem_read | ex_mem_write;
  assign accept   = (state_q == LSU_IDLE) & ex_valid & req_any;
  assign illegal  = (ex_access > 3'd4) | (ex_mem_read & ex_mem_write);
  assign misalign =
    (((ex_access == MEM_HALF) | (ex_access == MEM_HALF_U)) & ex_addr[0]) |
    ((ex_access == MEM_WORD) & (|ex_addr[1:0]));
  assign bad      = illegal | misalign;
  assign timeout  = (cnt_q == CNT_LAST);

  always_comb begin
    wdata_rep = wdata_q;
    unique case (1'b1)
      (acc_q == MEM_BYTE) || (acc_q == MEM_BYTE_U):
        wdata_rep = {4{wdata_q[7:0]}};
      (acc_q == MEM_HALF) || (acc_q == MEM_HALF_U):
        wdata_rep = {2{wdata_q[15:0]}};
      default:
        wdata_rep = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    acc_d   = acc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          we_d    = ex_mem_write;
          acc_d   = memAccessType_t'(ex_access);
          addr_d  = ex_addr;
          wdata_d = ex_wdata;
          cnt_d   = '0;
          if (bad) begin
            state_d = LSU_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = LSU_REQ;
            err_d   = 1'b0;
          end
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt & we_q) begin
          state_d = LSU_DONE;
          rdata_d = '0;
        end else if (mem_gnt & mem_rvalid) begin
          state_d = LSU_DONE;
          rdata_d = load_data;
        end else if (mem_gnt) begin
          state_d = LSU_WAIT_RESP;
        end else if (timeout) begin
          state_d = LSU_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      LSU_WAIT_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          state_d = LSU_DONE;
          rdata_d = load_data;
        end else if (timeout) begin
          state_d = LSU_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      acc_q   <= MEM_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory-side outputs are gated so they read 0 outside an active request.
  assign mem_req   = (state_q == LSU_REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wstrb = mem_we ? memStrobe(acc_q, addr_q[1:0]) : 4'b0000;
  assign mem_wdata = mem_we ? wdata_rep : '0;

  assign lsu_busy  = (state_q != LSU_IDLE) | (ex_valid & req_any);
  assign lsu_done  = (state_q == LSU_DONE);
  assign lsu_err   = lsu_done & err_q;
  assign lsu_rdata = rdata_q;

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Directed bench for riscv_lsu_ctrl.
// Hand-computed expectations checked with immediate assertions.
module tb_riscv_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_access;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic        lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks;
  int failures;
  int req_cycles;
  int done_seen;
  logic done_err;
  logic [31:0] done_rdata;

  riscv_lsu_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_access    (ex_access),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .lsu_busy     (lsu_busy),
    .lsu_done     (lsu_done),
    .lsu_err      (lsu_err),
    .lsu_rdata    (lsu_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] acc,
                       input logic [31:0] a, input logic [31:0] d);
    ex_valid     = 1'b1;
    ex_mem_read  = rd;
    ex_mem_write = wr;
    ex_access    = acc;
    ex_addr      = a;
    ex_wdata     = d;
  endtask

  task automatic idle_ex();
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    idle_ex();
    ex_access = 3'd0;
    ex_addr = '0;
    ex_wdata = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;

    // reset state
    #12;
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_busy", {31'h0, lsu_busy}, 32'h0);
    chk("rst_done", {31'h0, lsu_done}, 32'h0);
    chk("rst_rdata", lsu_rdata, 32'h0);
    chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
    step();
    rst = 1'b0;
    step();

    // SB to 0x1002, immediate grant
    issue(1'b0, 1'b1, 3'd0, 32'h1002, 32'h0000_00AB);
    #1 chk("sb_busy_acc", {31'h0, lsu_busy}, 32'h1);
    chk("sb_noreq_acc", {31'h0, mem_req}, 32'h0);
    step();
    idle_ex();
    mem_gnt = 1'b1;
    #1 chk("sb_req", {31'h0, mem_req}, 32'h1);
    chk("sb_we", {31'h0, mem_we}, 32'h1);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_wstrb", {28'h0, mem_wstrb}, 32'h4);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("sb_done_early", {31'h0, lsu_done}, 32'h0);
    step();
    mem_gnt = 1'b0;
    #1 chk("sb_done", {31'h0, lsu_done}, 32'h1);
    chk("sb_err", {31'h0, lsu_err}, 32'h0);
    chk("sb_busy_done", {31'h0, lsu_busy}, 32'h1);
    chk("sb_wstrb_off", {28'h0, mem_wstrb}, 32'h0);
    step();
    chk("sb_idle", {30'h0, lsu_done, lsu_busy}, 32'h0);

    // LB then LBU from 0x2003, rvalid one cycle after grant
    for (int k = 0; k < 2; k++) begin
      issue(1'b1, 1'b0, (k == 0) ? 3'd0 : 3'd3, 32'h2003, 32'h0);
      step();
      idle_ex();
      mem_gnt = 1'b1;
      #1 chk("lb_req", {31'h0, mem_req}, 32'h1);
      chk("lb_we", {31'h0, mem_we}, 32'h0);
      chk("lb_addr", mem_addr, 32'h2000);
      step();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = 32'h80FF_1234;
      #1 chk("lb_wait_noreq", {31'h0, mem_req}, 32'h0);
      chk("lb_wait_nodone", {31'h0, lsu_done}, 32'h0);
      step();
      mem_rvalid = 1'b0;
      #1 chk("lb_done", {31'h0, lsu_done}, 32'h1);
      chk("lb_err", {31'h0, lsu_err}, 32'h0);
      chk(k == 0 ? "lb_rdata" : "lbu_rdata", lsu_rdata,
          (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      step();
    end

    // LH misaligned at 0x3001
    issue(1'b1, 1'b0, 3'd1, 32'h3001, 32'h0);
    step();
    idle_ex();
    #1 chk("lh_mis_noreq", {31'h0, mem_req}, 32'h0);
    chk("lh_mis_done", {31'h0, lsu_done}, 32'h1);
    chk("lh_mis_err", {31'h0, lsu_err}, 32'h1);
    chk("lh_mis_rdata", lsu_rdata, 32'h0);
    step();
    chk("lh_mis_idle", {31'h0, lsu_done}, 32'h0);

    // illegal access code and read+write together
    issue(1'b1, 1'b0, 3'd6, 32'h3100, 32'h0);
    step();
    idle_ex();
    #1 chk("ill_acc_err", {30'h0, lsu_done, lsu_err}, 32'h3);
    chk("ill_acc_noreq", {31'h0, mem_req}, 32'h0);
    step();
    issue(1'b1, 1'b1, 3'd2, 32'h3200, 32'h0);
    step();
    idle_ex();
    #1 chk("ill_rw_err", {30'h0, lsu_done, lsu_err}, 32'h3);
    step();

    // LW at 0x4000, grant withheld: timeout, stray rvalid ignored
    issue(1'b1, 1'b0, 3'd2, 32'h4000, 32'h0);
    req_cycles = 0;
    done_seen = 0;
    done_err = 1'b0;
    done_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      step();
      idle_ex();
      mem_rvalid = (i == 3);
      mem_rdata = 32'h1111_2222;
      #1;
      if (mem_req) req_cycles++;
      if (lsu_done) begin
        done_seen++;
        done_err = lsu_err;
        done_rdata = lsu_rdata;
      end
    end
    mem_rvalid = 1'b0;
    chk("to_req_cycles", req_cycles, 32'd16);
    chk("to_done_once", done_seen, 32'd1);
    chk("to_err", {31'h0, done_err}, 32'h1);
    chk("to_rdata", done_rdata, 32'h0);

    // reset while waiting for the response
    issue(1'b1, 1'b0, 3'd2, 32'h4100, 32'h0);
    step();
    idle_ex();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #1 chk("rw_in_wait", {31'h0, lsu_busy}, 32'h1);
    #1 rst = 1'b1;
    #1 chk("rw_req", {31'h0, mem_req}, 32'h0);
    chk("rw_busy", {31'h0, lsu_busy}, 32'h0);
    chk("rw_done", {31'h0, lsu_done}, 32'h0);
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    step();
    mem_rvalid = 1'b0;
    chk("rw_late_rvalid", {30'h0, lsu_done, lsu_busy}, 32'h0);
    step();
    chk("rw_late_rvalid2", {31'h0, lsu_done}, 32'h0);

    // SW at 0x5000 after reset
    issue(1'b0, 1'b1, 3'd2, 32'h5000, 32'h1234_5678);
    step();
    idle_ex();
    mem_gnt = 1'b1;
    #1 chk("sw_wstrb", {28'h0, mem_wstrb}, 32'hF);
    chk("sw_wdata", mem_wdata, 32'h1234_5678);
    chk("sw_addr", mem_addr, 32'h5000);
    step();
    mem_gnt = 1'b0;
    #1 chk("sw_done", {30'h0, lsu_done, lsu_err}, 32'h2);
    step();

    // SH 0x6002 followed by LHU 0x6002 back to back
    issue(1'b0, 1'b1, 3'd1, 32'h6002, 32'h0000_CAFE);
    step();
    idle_ex();
    mem_gnt = 1'b1;
    #1 chk("sh_wstrb", {28'h0, mem_wstrb}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hCAFE_CAFE);
    step();
    mem_gnt = 1'b0;
    issue(1'b1, 1'b0, 3'd4, 32'h6002, 32'h0);
    #1 chk("sh_done", {31'h0, lsu_done}, 32'h1);
    chk("b2b_busy_done", {31'h0, lsu_busy}, 32'h1);
    step();
    chk("b2b_accept_idle", {30'h0, lsu_done, mem_req}, 32'h0);
    chk("b2b_accept_busy", {31'h0, lsu_busy}, 32'h1);
    step();
    idle_ex();
    mem_gnt = 1'b1;
    #1 chk("lhu_req", {31'h0, mem_req}, 32'h1);
    chk("lhu_addr", mem_addr, 32'h6000);
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBEEF_0000;
    step();
    mem_rvalid = 1'b0;
    chk("lhu_done", {30'h0, lsu_done, lsu_err}, 32'h2);
    chk("lhu_rdata", lsu_rdata, 32'h0000_BEEF);
    step();
    chk("lhu_rdata_hold", lsu_rdata, 32'h0000_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
